// File: rtl/stack_arbiter_if.sv
// Bundle of the two requester ports and the stack-side port of stack_arbiter.
// Handshake: a requester holds req (with op/wdata) high until it samples a one-cycle ack, and drops req on that edge.
interface stack_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int SP_W   = 8
);
    logic              r0_req;
    logic [1:0]        r0_op;
    logic [DATA_W-1:0] r0_wdata;
    logic              r0_ack;
    logic [DATA_W-1:0] r0_rdata;
    logic              r0_err;

    logic              r1_req;
    logic [1:0]        r1_op;
    logic [DATA_W-1:0] r1_wdata;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_rdata;
    logic              r1_err;

    logic              stk_enable;
    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_data_in;
    logic [DATA_W-1:0] stk_data_out;
    logic              stk_empty;
    logic [SP_W-1:0]   stk_sp;

    logic              busy;
    logic [7:0]        err_cnt;

    // Arbiter side: serves both requesters and masters the stack.
    modport master (
        input  r0_req, r0_op, r0_wdata, r1_req, r1_op, r1_wdata,
        input  stk_data_out, stk_empty, stk_sp,
        output r0_ack, r0_rdata, r0_err, r1_ack, r1_rdata, r1_err,
        output stk_enable, stk_push, stk_pop, stk_data_in,
        output busy, err_cnt
    );

    // Environment side: the requesters plus the stack itself.
    modport slave (
        output r0_req, r0_op, r0_wdata, r1_req, r1_op, r1_wdata,
        output stk_data_out, stk_empty, stk_sp,
        input  r0_ack, r0_rdata, r0_err, r1_ack, r1_rdata, r1_err,
        input  stk_enable, stk_push, stk_pop, stk_data_in,
        input  busy, err_cnt
    );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin two-port sequencer for a hardware stack: IDLE grants, EXEC drives the stack, RESP acks.
// Overflow/underflow ops are rejected with err and counted in a saturating err_cnt.
module stack_arbiter #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int SP_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    stack_arbiter_if.master  bus,
    output logic [1:0]       fsm_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] OP_SPRD = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_PEEK = 2'd3;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              gnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [7:0]        err_cnt_q;

    logic              grant_now;
    logic              grant_sel;
    logic              exec_err;
    logic [DATA_W-1:0] exec_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        grant_now       = 1'b0;
        grant_sel       = 1'b0;
        exec_err        = 1'b0;
        exec_rdata      = '0;
        bus.stk_enable  = 1'b0;
        bus.stk_push    = 1'b0;
        bus.stk_pop     = 1'b0;
        bus.stk_data_in = '0;
        case (state)
            IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    grant_now = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    if (bus.r0_req && bus.r1_req) grant_sel = ~last_grant;
                    else                          grant_sel = bus.r1_req;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
                case (op_q)
                    OP_PUSH: begin
                        if (bus.stk_sp >= SP_W'(DEPTH)) begin
                            exec_err = 1'b1;
                        end else begin
                            bus.stk_enable  = 1'b1;
                            bus.stk_push    = 1'b1;
                            bus.stk_data_in = wdata_q;
                        end
                    end
                    OP_POP: begin
                        if (bus.stk_empty) begin
                            exec_err = 1'b1;
                        end else begin
                            exec_rdata     = bus.stk_data_out;
                            bus.stk_enable = 1'b1;
                            bus.stk_pop    = 1'b1;
                        end
                    end
                    OP_PEEK: begin
                        if (bus.stk_empty) exec_err   = 1'b1;
                        else               exec_rdata = bus.stk_data_out;
                    end
                    default: exec_rdata = DATA_W'(bus.stk_sp);
                endcase
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= 1'b1;
            gnt        <= 1'b0;
            op_q       <= OP_SPRD;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (grant_now) begin
                gnt        <= grant_sel;
                last_grant <= grant_sel;
                op_q       <= grant_sel ? bus.r1_op    : bus.r0_op;
                wdata_q    <= grant_sel ? bus.r1_wdata : bus.r0_wdata;
            end
            if (state == EXEC) begin
                rdata_q <= exec_rdata;
                err_q   <= exec_err;
            end
            if (state == RESP && err_q && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Responses are gated by state so nothing leaks outside the granted port's RESP cycle.
    assign bus.r0_ack   = (state == RESP) && !gnt;
    assign bus.r1_ack   = (state == RESP) &&  gnt;
    assign bus.r0_rdata = bus.r0_ack ? rdata_q : '0;
    assign bus.r1_rdata = bus.r1_ack ? rdata_q : '0;
    assign bus.r0_err   = bus.r0_ack && err_q;
    assign bus.r1_err   = bus.r1_ack && err_q;
    assign bus.busy     = (state != IDLE);
    assign bus.err_cnt  = err_cnt_q;
    assign fsm_state    = state;
endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter: a table of single ops against a behavioural stack,
// plus hand-written overflow, round-robin and reset-abort sequences.
module tb_stack_arbiter;
    localparam logic [1:0] OP_SPRD = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_PEEK = 2'd3;

    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    stack_arbiter_if #(.DATA_W(32), .SP_W(8)) bus ();

    stack_arbiter #(.DATA_W(32), .DEPTH(64), .SP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.master),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- behavioural stack ----------------
    logic [31:0] mem [0:63];
    logic [7:0]  model_sp;

    always @(posedge clk) begin
        if (!rst) begin
            model_sp <= 8'd0;
        end else if (bus.stk_enable) begin
            if (bus.stk_push && model_sp < 8'd64) begin
                mem[model_sp[5:0]] <= bus.stk_data_in;
                model_sp <= model_sp + 8'd1;
            end else if (bus.stk_pop && model_sp != 8'd0) begin
                model_sp <= model_sp - 8'd1;
            end
        end
    end

    always_comb begin
        bus.stk_sp       = model_sp;
        bus.stk_empty    = (model_sp == 8'd0);
        bus.stk_data_out = (model_sp == 8'd0) ? 32'd0 : mem[6'(model_sp - 8'd1)];
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    int          o_lat, o_push, o_pop, o_en, o_both, o_other;
    logic [31:0] o_rdata, o_data_in;
    logic        o_err;

    // Entered in an IDLE cycle just after a rising edge; returns in the next IDLE cycle.
    task automatic run_op(input bit port, input logic [1:0] op, input logic [31:0] wdata);
        o_lat = -1; o_push = 0; o_pop = 0; o_en = 0; o_both = 0; o_other = 0;
        o_rdata = '0; o_err = 1'b0; o_data_in = '0;
        if (port) begin
            bus.r1_op = op; bus.r1_wdata = wdata; bus.r1_req = 1'b1;
        end else begin
            bus.r0_op = op; bus.r0_wdata = wdata; bus.r0_req = 1'b1;
        end
        // Cycle 0 is the IDLE cycle where req is seen; ack is due in cycle 2.
        for (int c = 0; c < 8 && o_lat < 0; c++) begin
            @(negedge clk);
            if (bus.stk_enable) o_en++;
            if (bus.stk_push) begin o_push++; o_data_in = bus.stk_data_in; end
            if (bus.stk_pop) o_pop++;
            if (bus.stk_push && bus.stk_pop) o_both++;
            if (port ? bus.r0_ack : bus.r1_ack) o_other++;
            if (port ? bus.r1_ack : bus.r0_ack) begin
                o_lat   = c;
                o_rdata = port ? bus.r1_rdata : bus.r0_rdata;
                o_err   = port ? bus.r1_err   : bus.r0_err;
            end
        end
        @(posedge clk); #1;
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
    endtask

    typedef struct {
        bit          port;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_push;
        bit          exp_pop;
        int          exp_sp;
        int          exp_err_cnt;
    } vec_t;

    task automatic check_vec(input vec_t v, input string tag);
        run_op(v.port, v.op, v.wdata);
        check({tag, " latency"},   o_lat,   2);
        check({tag, " rdata"},     o_rdata, v.exp_rdata);
        check({tag, " err"},       32'(o_err), 32'(v.exp_err));
        check({tag, " push"},      o_push,  32'(v.exp_push));
        check({tag, " pop"},       o_pop,   32'(v.exp_pop));
        check({tag, " enable"},    o_en,    32'(v.exp_push) + 32'(v.exp_pop));
        check({tag, " push&pop"},  o_both,  0);
        check({tag, " other ack"}, o_other, 0);
        if (v.exp_push) check({tag, " data_in"}, o_data_in, v.wdata);
        check({tag, " sp"},        32'(bus.stk_sp),  v.exp_sp);
        check({tag, " err_cnt"},   32'(bus.err_cnt), v.exp_err_cnt);
    endtask

    vec_t vecs [10];
    logic [31:0] exp_q [$];
    bit          gnt_q [$];

    initial begin
        int n_acks, both_ack, both_strobe, late_acks;

        //             port op       wdata         rdata         err push pop sp ec
        vecs[0] = '{1'b0, OP_PUSH, 32'hDEADBEEF, 32'h0,        0, 1, 0, 1, 0};
        vecs[1] = '{1'b0, OP_SPRD, 32'h0,        32'h1,        0, 0, 0, 1, 0};
        vecs[2] = '{1'b1, OP_POP,  32'h0,        32'hDEADBEEF, 0, 0, 1, 0, 0};
        vecs[3] = '{1'b0, OP_POP,  32'h0,        32'h0,        1, 0, 0, 0, 1};
        vecs[4] = '{1'b1, OP_PEEK, 32'h0,        32'h0,        1, 0, 0, 0, 2};
        vecs[5] = '{1'b0, OP_PUSH, 32'h11,       32'h0,        0, 1, 0, 1, 2};
        vecs[6] = '{1'b1, OP_PUSH, 32'h22,       32'h0,        0, 1, 0, 2, 2};
        vecs[7] = '{1'b1, OP_POP,  32'h0,        32'h22,       0, 0, 1, 1, 2};
        vecs[8] = '{1'b1, OP_PEEK, 32'h0,        32'h11,       0, 0, 0, 1, 2};
        vecs[9] = '{1'b0, OP_SPRD, 32'h0,        32'h1,        0, 0, 0, 1, 2};

        rst = 1'b0;
        bus.r0_req = 1'b0; bus.r0_op = OP_SPRD; bus.r0_wdata = '0;
        bus.r1_req = 1'b0; bus.r1_op = OP_SPRD; bus.r1_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset state",   32'(fsm_state),       0);
        check("reset busy",    32'(bus.busy),        0);
        check("reset err_cnt", 32'(bus.err_cnt),     0);
        check("reset strobes", {29'd0, bus.stk_enable, bus.stk_push, bus.stk_pop}, 0);
        check("reset acks",    {30'd0, bus.r0_ack, bus.r1_ack}, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) check_vec(vecs[i], $sformatf("v%0d", i));

        // Fill to DEPTH through r1 (sp 1 -> 64), then one overflowing push.
        for (int i = 0; i < 63; i++) run_op(1'b1, OP_PUSH, 32'h100 + 32'(i));
        check("fill sp", 32'(bus.stk_sp), 64);
        check("fill err_cnt", 32'(bus.err_cnt), 2);
        check_vec('{1'b1, OP_PUSH, 32'hBAD, 32'h0, 1, 0, 0, 64, 3}, "overflow");

        // Both ports hold req: last grant was r1, so r0,r1,r0,r1.
        gnt_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_q = '{32'h13E, 32'hA5};
        bus.r0_op = OP_POP;  bus.r0_wdata = '0;
        bus.r1_op = OP_PUSH; bus.r1_wdata = 32'hA5;
        bus.r0_req = 1'b1; bus.r1_req = 1'b1;
        n_acks = 0; both_ack = 0; both_strobe = 0;
        for (int c = 0; c < 40 && n_acks < 4; c++) begin
            @(negedge clk);
            if (bus.stk_push && bus.stk_pop) both_strobe++;
            if (bus.r0_ack && bus.r1_ack) both_ack++;
            if (bus.r0_ack || bus.r1_ack) begin
                n_acks++;
                if (gnt_q.size() > 0) check($sformatf("rr grant %0d", n_acks), 32'(bus.r1_ack), 32'(gnt_q.pop_front()));
                if (bus.r0_ack) begin
                    if (exp_q.size() > 0) check("rr r0 rdata", bus.r0_rdata, exp_q.pop_front());
                    else check("rr r0 extra ack", 32'(n_acks), 0);
                end
            end
        end
        @(posedge clk); #1;
        bus.r0_req = 1'b0; bus.r1_req = 1'b0;
        check("rr ack count",   n_acks,      4);
        check("rr double ack",  both_ack,    0);
        check("rr push&pop",    both_strobe, 0);
        check("rr exp_q empty", exp_q.size(), 0);
        check("rr sp",          32'(bus.stk_sp), 64);

        // Reset in the EXEC cycle of a PUSH aborts it.
        check_vec('{1'b1, OP_POP, 32'h0, 32'hA5, 0, 0, 1, 63, 3}, "pre-abort pop");
        bus.r0_op = OP_PUSH; bus.r0_wdata = 32'h77; bus.r0_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort exec push", 32'(bus.stk_push),    1);
        check("abort exec data", bus.stk_data_in,      32'h77);
        check("abort exec busy", 32'(bus.busy),        1);
        rst = 1'b0;
        bus.r0_req = 1'b0;
        @(negedge clk);
        check("abort state",   32'(fsm_state),     0);
        check("abort busy",    32'(bus.busy),      0);
        check("abort strobes", {29'd0, bus.stk_enable, bus.stk_push, bus.stk_pop}, 0);
        check("abort data_in", bus.stk_data_in,    0);
        check("abort acks",    {30'd0, bus.r0_ack, bus.r1_ack}, 0);
        check("abort rdata",   bus.r0_rdata | bus.r1_rdata, 0);
        check("abort err_cnt", 32'(bus.err_cnt),   0);
        @(posedge clk); #1;
        rst = 1'b1;
        late_acks = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.r0_ack || bus.r1_ack) late_acks++;
        end
        check("abort no ack", late_acks, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
